// File: rtl/raster_pkg.sv
// Shared rasteriser definitions: weight fixed-point format, interpolator states, colour type.
// Rounding mode of the interpolator is selected by ATTR_INTERP_ROUND_EN (see interp_mac).
package raster_pkg;

   localparam int WEIGHT_FRAC = 7;
   localparam int WEIGHT_ONE  = 1 << WEIGHT_FRAC;
   localparam int CH_MAX      = 255;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

endpackage

// File: rtl/interp_mac.sv
// Shared multiply-accumulate for the attribute interpolator: signed weight x unsigned channel,
// then normalise (truncate, or round half up when ATTR_INTERP_ROUND_EN is defined) and clamp.
module interp_mac
   import raster_pkg::*;
#(
   parameter int WEIGHT_W = 32,
   parameter int CH_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic [WEIGHT_W-1:0] w,
   input  logic [CH_W-1:0]     a,
   output logic [CH_W-1:0]     chan
);

   localparam int PROD_W = WEIGHT_W + CH_W + 1;
   localparam int ACC_W  = WEIGHT_W + CH_W + 3;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_reg;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  norm_in;
   logic signed [ACC_W-1:0]  norm;

   always_comb begin
      // Channel is zero-extended so the product stays signed without losing its top bit.
      prod = PROD_W'($signed(w)) * PROD_W'($signed({1'b0, a}));

      if (clr)
         acc_next = ACC_W'(prod);
      else
         acc_next = acc_reg + ACC_W'(prod);

`ifdef ATTR_INTERP_ROUND_EN
      norm_in = acc_next + ACC_W'(WEIGHT_ONE / 2);
`else
      norm_in = acc_next;
`endif
      norm = norm_in >>> WEIGHT_FRAC;

      if (norm < 0)
         chan = '0;
      else if (norm > ACC_W'(CH_MAX))
         chan = CH_W'(CH_MAX);
      else
         chan = norm[CH_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc_reg <= '0;
      else if (en)
         acc_reg <= acc_next;
   end

endmodule

// File: rtl/attribute_interpolator.sv
// Barycentric colour interpolator: one shared MAC walks 3 channels x 3 vertices per pixel.
// Build option ATTR_INTERP_ROUND_EN selects round-half-up normalisation instead of truncation.
module attribute_interpolator
   import raster_pkg::*;
#(
   parameter int WEIGHT_W = 32,
   parameter int CH_W     = 8,
   parameter int NUM_CH   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WEIGHT_W-1:0]      w0,
   input  logic [WEIGHT_W-1:0]      w1,
   input  logic [WEIGHT_W-1:0]      w2,
   input  logic [NUM_CH*CH_W-1:0]   a0,
   input  logic [NUM_CH*CH_W-1:0]   a1,
   input  logic [NUM_CH*CH_W-1:0]   a2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*CH_W-1:0]   rgb
);

   localparam int         PIX_W     = NUM_CH * CH_W;
   localparam logic [3:0] LAST_STEP = 4'(3 * NUM_CH - 1);

   state_t              state_reg, state_next;
   logic [3:0]          step_reg, step_next;
   logic [WEIGHT_W-1:0] w_reg [3];
   logic [WEIGHT_W-1:0] w_next [3];
   logic [PIX_W-1:0]    a_reg [3];
   logic [PIX_W-1:0]    a_next [3];
   logic [PIX_W-1:0]    rgb_reg, rgb_next;
   logic                out_valid_reg, out_valid_next;

   logic [1:0]          ch;
   logic [1:0]          v;
   logic [CH_W-1:0]     a_ch [NUM_CH];
   logic [CH_W-1:0]     mac_chan;
   logic                mac_en;

   assign ch = 2'(step_reg / 4'd3);
   assign v  = 2'(step_reg % 4'd3);

   // Channel 0 (R) lives in the most significant byte.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_sel
         assign a_ch[gi] = a_reg[v][(NUM_CH-1-gi)*CH_W +: CH_W];
      end
   endgenerate

   interp_mac #(
      .WEIGHT_W (WEIGHT_W),
      .CH_W     (CH_W)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .en   (mac_en),
      .clr  (v == 2'd0),
      .w    (w_reg[v]),
      .a    (a_ch[ch]),
      .chan (mac_chan)
   );

   always_comb begin
      state_next     = state_reg;
      step_next      = step_reg;
      w_next         = w_reg;
      a_next         = a_reg;
      rgb_next       = rgb_reg;
      out_valid_next = out_valid_reg;
      mac_en         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               w_next[0]  = w0;
               w_next[1]  = w1;
               w_next[2]  = w2;
               a_next[0]  = a0;
               a_next[1]  = a1;
               a_next[2]  = a2;
               step_next  = '0;
               state_next = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (v == 2'd2)
               rgb_next[(NUM_CH-1-int'(ch))*CH_W +: CH_W] = mac_chan;
            if (step_reg == LAST_STEP) begin
               state_next     = DONE;
               out_valid_next = 1'b1;
            end else begin
               step_next = step_reg + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         step_reg      <= '0;
         rgb_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         step_reg      <= step_next;
         rgb_reg       <= rgb_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // Operand capture needs no reset: it is only read after a fresh accept.
   always_ff @(posedge clk) begin
      w_reg <= w_next;
      a_reg <= a_next;
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = out_valid_reg;
   assign rgb       = rgb_reg;

endmodule

// File: tb/tb_attribute_interpolator.sv
// Scoreboard bench for attribute_interpolator; reference model honours ATTR_INTERP_ROUND_EN.
module tb_attribute_interpolator;
   import raster_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] w0, w1, w2;
   logic [23:0] a0, a1, a2;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] rgb;

   int n_vec  = 0;
   int n_miss = 0;
   logic [23:0] exp_q [$];

   attribute_interpolator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .w0        (w0),
      .w1        (w1),
      .w2        (w2),
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rgb       (rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [23:0] model(input logic [31:0] wa, input logic [31:0] wb,
                                         input logic [31:0] wc, input logic [23:0] pa,
                                         input logic [23:0] pb, input logic [23:0] pc);
      rgb888_t res;
      logic [7:0] c8 [3];
      longint acc;
      longint nrm;
      for (int c = 0; c < 3; c++) begin
         int sh;
         sh  = (2 - c) * 8;
         acc = longint'($signed(wa)) * longint'((pa >> sh) & 24'hFF)
             + longint'($signed(wb)) * longint'((pb >> sh) & 24'hFF)
             + longint'($signed(wc)) * longint'((pc >> sh) & 24'hFF);
`ifdef ATTR_INTERP_ROUND_EN
         acc = acc + 64;
`endif
         nrm = acc >>> 7;
         if (nrm < 0)        c8[c] = 8'd0;
         else if (nrm > 255) c8[c] = 8'd255;
         else                c8[c] = nrm[7:0];
      end
      res.r = c8[0];
      res.g = c8[1];
      res.b = c8[2];
      return res;
   endfunction

   // One pixel: accept, watch latency and in_ready, stall downstream for 'hold' cycles, release.
   task automatic run_px(input logic [31:0] wa, input logic [31:0] wb, input logic [31:0] wc,
                         input logic [23:0] pa, input logic [23:0] pb, input logic [23:0] pc,
                         input int hold);
      int lat;
      logic [23:0] want;
      logic [23:0] held;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      w0 = wa; w1 = wb; w2 = wc;
      a0 = pa; a1 = pb; a2 = pc;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back(model(wa, wb, wc, pa, pb, pc));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 9);
      want = exp_q.pop_front();
      check("rgb", 32'(rgb), 32'(want));
      $display("px w=(%0d,%0d,%0d) a=(%h,%h,%h) rgb=%h exp=%h lat=%0d", $signed(wa), $signed(wb),
               $signed(wc), pa, pb, pc, rgb, want, lat);
      held = rgb;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_rgb", 32'(rgb), 32'(held));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_rgb", 32'(rgb), 32'(held));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      w0 = '0; w1 = '0; w2 = '0; a0 = '0; a1 = '0; a2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_rgb", 32'(rgb), 32'd0);
      rst = 1'b0;

      run_px(32'd128, 32'd0, 32'd0, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0);
      run_px(32'd0, 32'd64, 32'd64, 24'h123456, 24'h00FF00, 24'h000000, 0);
      run_px(32'd128, 32'd128, 32'd0, 24'hC0C0C0, 24'hC0C0C0, 24'h000000, 0);
      run_px(32'hFFFFFFC0, 32'd192, 32'd0, 24'hFFFFFF, 24'h000000, 24'h55AA33, 0);
      run_px(32'd40, 32'd50, 32'd38, 24'h10E080, 24'h7F01FE, 24'hA5005A, 5);

      // Reset while the MAC is at step 4: pixel must be dropped.
      w0 = 32'd128; w1 = '0; w2 = '0; a0 = 24'hFFFFFF; a1 = '0; a2 = '0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      $display("reset at MAC step 4: in_ready=%0d out_valid=%0d", in_ready, out_valid);

      run_px(32'd43, 32'd43, 32'd42, 24'h646464, 24'h646464, 24'h646464, 0);

      for (int k = 0; k < 6; k++) begin
         logic [31:0] ra, rb, rc;
         ra = 32'($urandom_range(0, 200)) - 32'd40;
         rb = 32'($urandom_range(0, 200)) - 32'd40;
         rc = 32'd128 - ra - rb;
         run_px(ra, rb, rc, 24'($urandom), 24'($urandom), 24'($urandom),
                int'($urandom_range(0, 3)));
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/attribute_interpolator.md
Name: attribute_interpolator

Overview:
- Consumes barycentric weights (w0, w1, w2) from the weight stage, together with the three per-vertex RGB888 colours, and produces the interpolated pixel colour.
- Sits between the weight calculator and the pixel write/shading stage of the rasteriser.
- Uses one shared multiplier, time-multiplexed over 3 channels x 3 vertices, with valid/ready on both sides.

Parameters:
- WEIGHT_W, 32, weight width; signed two's complement.
- WEIGHT_FRAC, 7, weight fractional bits; 1.0 = 128, and inside-triangle weights sum to 128.
- CH_W, 8, bits per colour channel.
- NUM_CH, 3, channels per attribute (R, G, B; R in MSBs).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  weights + attributes valid.
- in_ready  out  1  block can accept.
- w0, w1, w2  in  WEIGHT_W each  barycentric weights, signed Q(WEIGHT_W-7).7.
- a0, a1, a2  in  NUM_CH*CH_W each  vertex colours (unsigned).
- out_valid  out  1  rgb valid.
- out_ready  in  1  downstream accepts.
- rgb  out  NUM_CH*CH_W  interpolated colour.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, rgb=0, acc=0, step=0.
- FSM: IDLE -> MAC -> DONE -> IDLE. in_ready = (state==IDLE); no other state accepts input.
- IDLE: on an edge with in_valid&&in_ready, capture all weights and attributes, set step=0, go to MAC.
- MAC, steps 0..8, one per edge:
  - ch = step/3 (0=R, 1=G, 2=B); v = step%3.
  - prod = signed w_v x zero-extended a_v[ch] (WEIGHT_W+CH_W+1 bits).
  - acc_next = (v==0 ? 0 : acc) + prod. acc width is WEIGHT_W+CH_W+3 bits, so no overflow.
- Channel write (when v==2): chan[ch] = clamp(norm(acc_next)).
  - norm = arithmetic shift right by WEIGHT_FRAC, with rounding per the Optional Feature.
  - clamp: negative -> 0; >255 -> 255.
- Step 8: write the B channel, go to DONE, out_valid<=1 on the same edge.
- Latency: out_valid rises 9 edges after the accept edge. Throughput is 1 pixel per 11 cycles minimum.
- DONE: rgb and out_valid held stable while out_ready=0. On an edge with out_ready=1: out_valid<=0, go to IDLE. rgb keeps its last value.
- in_valid while busy is ignored; the upstream must hold it.
- Weights outside the triangle (negative, or sum != 128) are legal; saturation covers them.
- rst mid-MAC or in DONE: next cycle is IDLE, the transaction is discarded, and out_valid=0.

Optional Feature:
- Macro ATTR_INTERP_ROUND_EN.
- Defined: norm = (acc + 2^(WEIGHT_FRAC-1)) >>> WEIGHT_FRAC, i.e. round half up.
- Undefined: norm = acc >>> WEIGHT_FRAC, i.e. truncate toward -inf.
- Latency is identical in both builds.

Decomposition:
- Shared package raster_pkg holds:
  - WEIGHT_ONE=128 and WEIGHT_FRAC;
  - the state enum {IDLE, MAC, DONE};
  - the rgb888 typedef;
  - the CH_MAX=255 constant.
- Sub-module interp_mac: signed multiply, accumulate/clear, normalise and clamp. Purely combinational datapath plus the acc register.
- The FSM and operand muxing stay in the top module.

Test Plan:
- w=(128,0,0), a0=FF0000, a1=00FF00, a2=0000FF, out_ready=1 -> rgb=FF0000, out_valid exactly 9 edges after accept, in_ready low throughout.
- w=(0,64,64), a1=00FF00, a2=000000 -> G=0x80 with ATTR_INTERP_ROUND_EN, 0x7F without; R=B=00.
- w=(128,128,0), a0=a1=C0C0C0 -> rgb=FFFFFF (saturation).
- w0=FFFFFFC0 (-64), w1=192, w2=0, a0=FFFFFF, a1=000000 -> rgb=000000 (negative clamp).
- out_ready=0 for 5 cycles after out_valid -> rgb and out_valid stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Assert rst at MAC step 4 -> next cycle in_ready=1, out_valid=0. A new transaction w=(43,43,42), a0=a1=a2=646464 then gives rgb=646464.
